// File: rtl/reg_hazard_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// reg_hazard_scoreboard_pkg
//   Shared CPU constants used by the register-hazard scoreboard and its
//   counter sub-module.
//   Opcode constants describe the instruction set that the control path
//   decodes. The scoreboard itself depends only on the decoded control flags.
//   NREGS / RNUM_W  : architectural register file size and index width.
//   WB_DEPTH        : cycles from issue until a written value is readable.
//   LOAD_EXTRA      : extra busy cycles for memory-sourced writes.
//   CNT_W           : countdown width; it must hold WB_DEPTH + LOAD_EXTRA.
// ---------------------------------------------------------------------------
package reg_hazard_scoreboard_pkg;

  localparam int NREGS      = 32;
  localparam int RNUM_W     = 5;   // log2(NREGS)
  localparam int WB_DEPTH   = 3;
  localparam int LOAD_EXTRA = 1;
  localparam int CNT_W      = 3;   // holds WB_DEPTH + LOAD_EXTRA = 4

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  // Countdown reload value for a freshly issued write.
  function automatic logic [CNT_W-1:0] busy_cycles(input logic from_mem);
    busy_cycles = from_mem ? CNT_W'(WB_DEPTH + LOAD_EXTRA) : CNT_W'(WB_DEPTH);
  endfunction

endpackage

// File: rtl/reg_hazard_scoreboard_busy_counter.sv
// ---------------------------------------------------------------------------
// reg_busy_counter
//   One countdown that tracks a single register's pending write.
//   Ports:
//     clk, rst      : clock, asynchronous active-high reset
//     i_load        : reload the countdown this edge (takes priority)
//     i_load_val    : value to reload
//     o_busy        : current count is non-zero
//     o_next_busy   : count after the coming edge is non-zero
// ---------------------------------------------------------------------------
import reg_hazard_scoreboard_pkg::*;

module reg_busy_counter (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_busy,
  output logic             o_next_busy
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  // A reload replaces the remaining count, so a WAW reissue restarts the
  // full window instead of accumulating. An idle counter holds at zero.
  always_comb begin
    w_cnt_next = r_cnt;
    if (i_load) begin
      w_cnt_next = i_load_val;
    end else if (r_cnt != '0) begin
      w_cnt_next = r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  assign o_busy      = (r_cnt != '0);
  assign o_next_busy = (w_cnt_next != '0);

endmodule

// File: rtl/reg_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_hazard_scoreboard
//   Tracks in-flight register writes issued from decode and flags source
//   operand conflicts for the instruction currently in decode.
//   Ports:
//     clk, rst            : clock, asynchronous active-high reset
//     rs, rt, rd          : decode register fields
//     is_R_type/is_I_type : instruction format from the control path
//     is_write_reg        : instruction writes a register
//     is_write_from_mem   : write data comes from memory (load)
//     is_nop              : decode slot is a bubble this cycle
//     is_full_rnum1/2     : rs / rt has a pending write (combinational)
//     busy_mask           : registered per-register busy bits
//     pending_cnt         : registered number of busy registers
// ---------------------------------------------------------------------------
import reg_hazard_scoreboard_pkg::*;

module reg_hazard_scoreboard (
  input  logic              clk,
  input  logic              rst,
  input  logic [RNUM_W-1:0] rs,
  input  logic [RNUM_W-1:0] rt,
  input  logic [RNUM_W-1:0] rd,
  input  logic              is_R_type,
  input  logic              is_I_type,
  input  logic              is_write_reg,
  input  logic              is_write_from_mem,
  input  logic              is_nop,
  output logic              is_full_rnum1,
  output logic              is_full_rnum2,
  output logic [NREGS-1:0]  busy_mask,
  output logic [RNUM_W:0]   pending_cnt
);

  logic [RNUM_W-1:0] w_dest;
  logic              w_issue;
  logic [CNT_W-1:0]  w_load_val;
  logic [NREGS-1:0]  w_busy;
  logic [NREGS-1:0]  w_next_busy;
  logic [RNUM_W:0]   w_pending_next;
  logic [NREGS-1:0]  r_busy_mask;
  logic [RNUM_W:0]   r_pending_cnt;

  assign w_dest = is_R_type ? rd : rt;

  // Register 0 is hardwired zero, so a write to it never creates a hazard.
  assign w_issue = !rst && !is_nop && is_write_reg &&
                   (is_R_type || is_I_type) && (w_dest != '0);

  assign w_load_val = busy_cycles(is_write_from_mem);

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_cnt
      reg_busy_counter u_cnt (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_issue && (w_dest == RNUM_W'(gi))),
        .i_load_val  (w_load_val),
        .o_busy      (w_busy[gi]),
        .o_next_busy (w_next_busy[gi])
      );
    end
  endgenerate

  // The popcount is taken over next-state bits so that the registered count
  // lines up with the counters on the same edge.
  always_comb begin
    w_pending_next = '0;
    for (int i = 0; i < NREGS; i++) begin
      w_pending_next = w_pending_next + {{RNUM_W{1'b0}}, w_next_busy[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy_mask   <= '0;
      r_pending_cnt <= '0;
    end else begin
      r_busy_mask   <= w_next_busy;
      r_pending_cnt <= w_pending_next;
    end
  end

  assign busy_mask   = r_busy_mask;
  assign pending_cnt = r_pending_cnt;

  // The flags look only at registered counters, never at the same-cycle
  // issue. This keeps the stall path free of a combinational loop through
  // the control path.
  assign is_full_rnum1 = (rs != '0) && w_busy[rs];
  assign is_full_rnum2 = (rt != '0) && w_busy[rt];

endmodule

// File: tb/tb_reg_hazard_scoreboard.sv
module tb_reg_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rs = '0, rt = '0, rd = '0;
  logic        is_R_type = 1'b0, is_I_type = 1'b0, is_write_reg = 1'b0;
  logic        is_write_from_mem = 1'b0, is_nop = 1'b0;
  logic        is_full_rnum1, is_full_rnum2;
  logic [31:0] busy_mask;
  logic [5:0]  pending_cnt;

  always #5 clk = ~clk;

  reg_hazard_scoreboard dut (
    .clk               (clk),
    .rst               (rst),
    .rs                (rs),
    .rt                (rt),
    .rd                (rd),
    .is_R_type         (is_R_type),
    .is_I_type         (is_I_type),
    .is_write_reg      (is_write_reg),
    .is_write_from_mem (is_write_from_mem),
    .is_nop            (is_nop),
    .is_full_rnum1     (is_full_rnum1),
    .is_full_rnum2     (is_full_rnum2),
    .busy_mask         (busy_mask),
    .pending_cnt       (pending_cnt)
  );

  typedef struct {
    int          id;
    logic        f1;
    logic        f2;
    logic [31:0] mask;
    logic [5:0]  pc;
  } exp_t;

  exp_t exp_q[$];
  int   vec_id = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  // One vector per cycle: drive inputs just after the edge and queue the
  // outputs expected for that cycle (before the next edge).
  task automatic cyc(input logic r, input logic [4:0] a_rs, input logic [4:0] a_rt,
                     input logic [4:0] a_rd, input logic a_R, input logic a_I,
                     input logic a_wr, input logic a_mem, input logic a_nop,
                     input logic e1, input logic e2, input logic [31:0] em,
                     input logic [5:0] ep);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; rs = a_rs; rt = a_rt; rd = a_rd;
    is_R_type = a_R; is_I_type = a_I; is_write_reg = a_wr;
    is_write_from_mem = a_mem; is_nop = a_nop;
    e.id = vec_id; e.f1 = e1; e.f2 = e2; e.mask = em; e.pc = ep;
    vec_id++;
    exp_q.push_back(e);
  endtask

  // Cycle with no instruction issued; only source fields are presented.
  task automatic idle(input logic [4:0] a_rs, input logic [4:0] a_rt,
                      input logic e1, input logic e2, input logic [31:0] em,
                      input logic [5:0] ep);
    cyc(1'b0, a_rs, a_rt, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e1, e2, em, ep);
  endtask

  task automatic chk(input int id, input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL vec %0d %s: got %0h expected %0h", id, nm, act, req);
  endtask

  // Monitor: pops one expectation per cycle, away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      $display("vec %0d: f1=%0b f2=%0b mask=%08h pend=%0d", e.id,
               is_full_rnum1, is_full_rnum2, busy_mask, pending_cnt);
      chk(e.id, "is_full_rnum1", {31'd0, is_full_rnum1}, {31'd0, e.f1});
      chk(e.id, "is_full_rnum2", {31'd0, is_full_rnum2}, {31'd0, e.f2});
      chk(e.id, "busy_mask", busy_mask, e.mask);
      chk(e.id, "pending_cnt", {26'd0, pending_cnt}, {26'd0, e.pc});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //   rst rs  rt  rd  R  I  wr mem nop | f1 f2 mask pend
    // Reset state
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0, 0);
    cyc(1, 5, 7, 5, 1, 0, 1, 0, 0,  0, 0, 32'h0, 0);
    idle(0, 0, 0, 0, 32'h0, 0);

    // R-type write to r5: busy exactly 3 cycles
    cyc(0, 5, 0, 5, 1, 0, 1, 0, 0,  0, 0, 32'h0, 0);
    idle(5, 0, 1, 0, 32'h20, 1);
    idle(5, 0, 1, 0, 32'h20, 1);
    idle(5, 0, 1, 0, 32'h20, 1);
    idle(5, 0, 0, 0, 32'h0, 0);

    // Load to r7 (I-type): busy 4 cycles
    cyc(0, 0, 7, 0, 0, 1, 1, 1, 0,  0, 0, 32'h0, 0);
    idle(0, 7, 0, 1, 32'h80, 1);
    idle(0, 7, 0, 1, 32'h80, 1);
    idle(0, 7, 0, 1, 32'h80, 1);
    idle(0, 7, 0, 1, 32'h80, 1);
    idle(0, 7, 0, 0, 32'h0, 0);

    // Register 0 is never busy
    cyc(0, 0, 0, 0, 1, 0, 1, 0, 0,  0, 0, 32'h0, 0);
    idle(0, 0, 0, 0, 32'h0, 0);

    // WAW reload on r9: 5 busy cycles total, then a nop issue does nothing
    cyc(0, 9, 0, 9, 1, 0, 1, 0, 0,  0, 0, 32'h0, 0);
    idle(9, 0, 1, 0, 32'h200, 1);
    cyc(0, 9, 0, 9, 1, 0, 1, 0, 0,  1, 0, 32'h200, 1);
    idle(9, 0, 1, 0, 32'h200, 1);
    idle(9, 0, 1, 0, 32'h200, 1);
    idle(9, 0, 1, 0, 32'h200, 1);
    cyc(0, 9, 0, 9, 1, 0, 1, 0, 1,  0, 0, 32'h0, 0);
    idle(9, 0, 0, 0, 32'h0, 0);

    // Overlapping writes to r3, r4, r6
    cyc(0, 0, 0, 3, 1, 0, 1, 0, 0,  0, 0, 32'h0, 0);
    cyc(0, 0, 0, 4, 1, 0, 1, 0, 0,  0, 0, 32'h8, 1);
    cyc(0, 4, 6, 6, 1, 0, 1, 0, 0,  1, 0, 32'h18, 2);
    idle(4, 6, 1, 1, 32'h58, 3);
    idle(4, 6, 1, 1, 32'h50, 2);
    idle(4, 6, 0, 1, 32'h40, 1);
    idle(4, 6, 0, 0, 32'h0, 0);

    // Asynchronous reset mid-cycle with r10 (load), r11, r12 busy
    cyc(0, 0, 0, 0, 0, 1, 1, 1, 0,  0, 0, 32'h0, 0);      // I-type rt=0: no issue
    cyc(0, 0, 10, 0, 0, 1, 1, 1, 0,  0, 0, 32'h0, 0);     // load r10
    cyc(0, 0, 0, 11, 1, 0, 1, 0, 0,  0, 0, 32'h400, 1);   // r11
    cyc(0, 0, 0, 12, 1, 0, 1, 0, 0,  0, 0, 32'hC00, 2);   // r12
    idle(10, 11, 1, 1, 32'h1C00, 3);
    cyc(1, 10, 11, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0, 0);    // reset mid-cycle
    idle(10, 12, 0, 0, 32'h0, 0);

    @(posedge clk);
    @(negedge clk);
    #1;
    chk(-1, "queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
